// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered multiplexer: selection modes
// and the round-robin pointer advance rule.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Pointer advance after a grant on channel g. The wrap happens at the
  // channel count, not at the pointer's binary width, so non-power-of-two
  // channel counts never point at a channel that does not exist.
  function automatic int unsigned rr_next_ptr(input int unsigned g, input int unsigned n);
    return (g >= n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The request vector is rotated so that
// position 0 is the channel at ptr, then a fixed-priority encoder picks the
// lowest rotated position, and the winner is mapped back to its channel index.
module rr_arbiter #(
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [N_IN-1:0] rot;

  // Rotate requests so rot[k] is the request of channel (ptr + k) mod N_IN.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    rot = '0;
    for (int k = 0; k < N_IN; k++) begin
      rot[k] = req[(int'(ptr) + k) % N_IN];
    end
  end

  // Priority-encode the rotated vector; scanning downward lets the lowest
  // rotated position, i.e. the one closest to ptr, win.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'((int'(ptr) + k) % N_IN);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// Registered N:1 multiplexer with per-channel valid/ready. The selected
// channel comes either from an external select (fixed mode) or from a
// round-robin arbiter; one output register stage with skid-free flow control.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             fix_valid;
  logic [SEL_W-1:0] fix_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(.N_IN(N_IN)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Fixed-select grant by comparison against each legal index, so a select
  // beyond the last channel simply matches nothing instead of indexing out of range.
  always_comb begin
    fix_valid = 1'b0;
    fix_idx   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        fix_valid = 1'b1;
        fix_idx   = SEL_W'(i);
      end
    end
  end

  // Choose the grant source by mode; mode changes act in the same cycle.
  always_comb begin
    gnt_valid = fix_valid;
    gnt_idx   = fix_idx;
    if (mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end
  end

  // Register may load when empty or draining this cycle; held off during
  // reset so no channel sees ready while rst_n is low.
  assign load_en = rst_n && (!out_valid || out_ready);
  assign xfer    = load_en && gnt_valid;

  // Data mux and one-hot ready for the granted channel.
  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = xfer;
      end
    end
  end

  // Output register: load on input transfer, empty when loadable with no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
    end else if (load_en) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      if (gnt_valid) begin
        out_data  <= gnt_data;
        out_src   <= gnt_idx;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: advances past the winner only on a round-robin transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && mode == MODE_RR) begin
      ptr <= SEL_W'(rr_next_ptr(32'(gnt_idx), N_IN));
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: a 4-channel and a 3-channel instance share stimulus.
// A behavioural model predicts grants and in_ready; predicted transfers are
// queued and popped when the registered output should show them.
module tb_mux_nx1_rr;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [1:0]    sel;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_valid;
  logic          out_ready;

  logic [3:0]    in_ready_a;
  logic [W-1:0]  out_data_a;
  logic [1:0]    out_src_a;
  logic          out_valid_a;

  logic [2:0]    in_ready_b;
  logic [W-1:0]  out_data_b;
  logic [1:0]    out_src_b;
  logic          out_valid_b;

  int total = 0;
  int bad   = 0;

  // Model state per instance (0 = four channels, 1 = three channels).
  int          m_ptr [2];
  logic        m_ov  [2];
  logic [33:0] m_last[2];
  logic [33:0] sb_a[$];
  logic [33:0] sb_b[$];

  always #5 clk = ~clk;

  mux_nx1_rr #(.WIDTH(W), .N_IN(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .out_data  (out_data_a),
    .out_src   (out_src_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready)
  );

  mux_nx1_rr #(.WIDTH(W), .N_IN(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data[3*W-1:0]),
    .in_valid  (in_valid[2:0]),
    .in_ready  (in_ready_b),
    .out_data  (out_data_b),
    .out_src   (out_src_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]  = 0;
      m_ov[d]   = 1'b0;
      m_last[d] = '0;
    end
    sb_a.delete();
    sb_b.delete();
  endtask

  // Hold reset with everything valid and check the cleared state.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b0;
    #1;
    model_reset();
    check("rst_ready_a", 64'(in_ready_a), 64'h0);
    check("rst_ready_b", 64'(in_ready_b), 64'h0);
    check("rst_valid_a", 64'(out_valid_a), 64'h0);
    check("rst_valid_b", 64'(out_valid_b), 64'h0);
    check("rst_data_a",  64'(out_data_a), 64'h0);
    check("rst_src_a",   64'(out_src_a), 64'h0);
    @(posedge clk);
    #1;
    check("rst_hold_ready_a", 64'(in_ready_a), 64'h0);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of stimulus, check in_ready before the edge and the
  // registered outputs just after it, for both instances.
  task automatic step(input logic md, input logic [1:0] s, input logic [3:0] v, input logic ordy);
    logic xf[2];
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    #1;
    for (int d = 0; d < 2; d++) begin
      int n;
      int g;
      logic ld;
      logic [3:0] exp_rdy;
      logic [3:0] act_rdy;
      n  = (d == 0) ? 4 : 3;
      g  = -1;
      ld = !m_ov[d] || ordy;
      if (md == 1'b0) begin
        if (int'(s) < n && v[s]) g = int'(s);
      end else begin
        for (int k = 0; k < n; k++) begin
          int idx;
          idx = (m_ptr[d] + k) % n;
          if (g < 0 && v[idx]) g = idx;
        end
      end
      exp_rdy = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
      act_rdy = (d == 0) ? in_ready_a : {1'b0, in_ready_b};
      check((d == 0) ? "in_ready_a" : "in_ready_b", 64'(act_rdy), 64'(exp_rdy));
      xf[d] = ld && g >= 0;
      if (xf[d]) begin
        logic [33:0] e;
        e = {in_data[g*W +: W], 2'(g)};
        if (d == 0) sb_a.push_back(e); else sb_b.push_back(e);
        m_ov[d]   = 1'b1;
        m_last[d] = e;
        if (md == 1'b1) m_ptr[d] = (g == n - 1) ? 0 : g + 1;
      end else if (ld) begin
        m_ov[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [33:0] act;
      logic        av;
      act = (d == 0) ? {out_data_a, out_src_a} : {out_data_b, out_src_b};
      av  = (d == 0) ? out_valid_a : out_valid_b;
      if (xf[d]) begin
        logic [33:0] e;
        e = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check((d == 0) ? "out_data_a" : "out_data_b", 64'(act[33:2]), 64'(e[33:2]));
        check((d == 0) ? "out_src_a" : "out_src_b", 64'(act[1:0]), 64'(e[1:0]));
        check((d == 0) ? "out_valid_a" : "out_valid_b", 64'(av), 64'h1);
      end else begin
        check((d == 0) ? "idle_valid_a" : "idle_valid_b", 64'(av), 64'(m_ov[d]));
        if (m_ov[d]) check((d == 0) ? "hold_a" : "hold_b", 64'(act), 64'(m_last[d]));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'(32'hA0 + i);
    #2;
    do_reset();

    // Round-robin, all valid: first grant is channel 0, then 0..3 repeating.
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 4'hF, 1'b1);

    // Fixed select stepping 0..3; sel=3 is no grant on the 3-channel instance.
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 4'hF, 1'b1);

    // Round-robin with only channels 1 and 3 valid: alternates, ptr wraps.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 4'b1010, 1'b1);

    // Backpressure while holding channel 2 data, then release.
    step(1'b0, 2'd2, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 4'hF, 1'b0);
    step(1'b0, 2'd1, 4'hF, 1'b1);
    step(1'b0, 2'd1, 4'h0, 1'b1);

    // Randomised mix of modes, selects, valids, data and backpressure.
    for (int i = 0; i < 60; i++) begin
      for (int c = 0; c < 4; c++) in_data[c*W +: W] = $urandom;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
           $urandom_range(0, 3) != 0);
    end

    // Reset mid-operation with pending data; round-robin restarts at channel 0.
    step(1'b1, 2'd0, 4'hF, 1'b0);
    do_reset();
    step(1'b1, 2'd0, 4'hF, 1'b1);
    step(1'b1, 2'd0, 4'hF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised, registered N:1 multiplexer with per-input valid/ready handshakes and two selection modes. Mode 0 uses an externally driven select. Mode 1 uses round-robin arbitration. It generalises the 4:1 bit-select mux of the 1-bit ALU datapath to W-bit operands and N sources, and sits in the 32-bit ALU datapath in front of the result/writeback register. There, several producers (adder, logic unit, shifter, comparator) share one output path under flow control.

## Interface
Parameters:
- WIDTH, 32, data width of every input and of the output
- N_IN, 4, number of input channels; legal range 2..16
- SEL_W, derived localparam = $clog2(N_IN), not overridable

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally
- mode  input  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR)
- sel  input  SEL_W  channel index used in MODE_FIXED; ignored in MODE_RR
- in_data  input  N_IN*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_IN  per-channel valid
- in_ready  output  N_IN  per-channel ready; combinational, at most one bit high
- out_data  output  WIDTH  registered selected data
- out_src  output  SEL_W  registered index of the channel that supplied out_data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready

## Operation
- One output register stage. load_en = !out_valid || out_ready.
- Grant, combinational:
  - MODE_FIXED: grant = sel if sel < N_IN and in_valid[sel]; otherwise no grant.
  - MODE_RR: first i with in_valid[i] set, searching ptr, ptr+1, … wrapping modulo N_IN; no grant if in_valid is all zero.
- in_ready[g] = load_en for the granted channel g. All other in_ready bits are 0.
- Input transfer on channel g when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= channel g data
  - out_src <= g
  - out_valid <= 1
- If load_en is high and there is no grant, out_valid <= 0. out_data and out_src hold.
- Output transfer when out_valid && out_ready.
- While out_valid && !out_ready, out_data, out_src and out_valid hold, and all in_ready bits are 0.
- ptr (SEL_W bits):
  - Updates only on an input transfer in MODE_RR: ptr <= (g == N_IN-1) ? 0 : g+1.
  - Holds in MODE_FIXED.
  - Wraps at N_IN, not at 2^SEL_W, for non-power-of-two N_IN.
- Mode or sel changes take effect combinationally for the grant in the same cycle. No in-flight data is dropped; the registered output is unaffected.
- sel >= N_IN (possible only for non-power-of-two N_IN) behaves as no grant. It is never an X-select.

## Timing
- Reset (asynchronous, rst_n low): out_valid = 0, out_data = 0, out_src = 0, ptr = 0. in_ready is all zero while rst_n is low.
- Latency: input transfer at edge k gives out_valid = 1 with that data after edge k.
- Throughput: one transfer per cycle when out_ready is held high.
- A simultaneous output transfer and input transfer in the same cycle is legal. The register is replaced with no bubble.
- Reset asserted mid-operation clears the register and ptr immediately. Pending out_data is discarded. The first grant after reset in MODE_RR starts at channel 0.
- in_ready depends on in_valid, mode, sel and out_ready combinationally. Upstream must not make in_valid depend on in_ready.

## Structure
- Package mux_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1
  - a function computing the round-robin next pointer modulo N_IN
- Sub-module rr_arbiter #(N_IN): inputs req, ptr; outputs gnt_valid and gnt_idx (SEL_W). It is purely combinational, rotate-then-priority-encode. mux_nx1_rr instantiates it and muxes it against the fixed-select grant.

## Test plan
- Reset: hold rst_n = 0 with all in_valid = 1 → in_ready = 0000, out_valid = 0, out_data = 0. Release; in MODE_RR the first accepted channel is 0.
- MODE_FIXED, N_IN = 4, WIDTH = 32, inputs 0xA0..0xA3 all valid, out_ready = 1, sel stepping 0,1,2,3 → out_data is 0xA0, 0xA1, 0xA2, 0xA3 one cycle after each sel, and out_src matches.
- MODE_RR, all four valid, out_ready = 1 for 8 cycles → out_src sequence is 0,1,2,3,0,1,2,3.
- MODE_RR, only channels 1 and 3 valid → out_src alternates 1,3,1,3; ptr wraps from 3 to 0.
- Backpressure: out_ready = 0 for 3 cycles while holding 0xA2 → out_data stays 0xA2, in_ready = 0000. Raise out_ready → the next transfer completes in the same cycle.
- N_IN = 3, MODE_FIXED with sel = 3 → no grant, out_valid drops to 0. MODE_RR after a grant on channel 2 → next grant search starts at channel 0.
